// File: rtl/primogen_wide.sv
// rtl/primogen_wide.sv - parametrised sequential prime generator with go/load handshake
module primogen_wide #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    output logic             ready,
    output logic             error,
    output logic [WIDTH-1:0] res
);

    // Candidate and divisor carry one extra bit so that stepping past 2**WIDTH-1 is visible.
    localparam int CW   = WIDTH + 1;
    localparam int SW   = 2 * WIDTH + 2;
    localparam int CNTW = $clog2(WIDTH + 1);

    localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO_W = WIDTH'(2);
    localparam logic [CW-1:0]    C_MAX = {1'b0, {WIDTH{1'b1}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_CHECK = 2'd2,
        S_DIV   = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic             req_load;
    logic [WIDTH-1:0] seed_q;
    logic [CW-1:0]    c;
    logic [CW-1:0]    d;
    logic [SW-1:0]    sq;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] cshift;
    logic [CNTW-1:0]  cnt;

    logic             chk_fail;
    logic             chk_found;
    logic             div_last;
    logic [CW-1:0]    rem_sh;
    logic [WIDTH-1:0] rem_nxt;
    logic [SW-1:0]    d_ext;
    logic [SW-1:0]    c_ext;

    // Datapath decisions: overflow, primality by square bound, one restoring division step
    always_comb begin
        c_ext     = {{(SW-CW){1'b0}}, c};
        d_ext     = {{(SW-CW){1'b0}}, d};
        chk_fail  = (c > C_MAX);
        chk_found = (c <= CW'(3)) || (sq > c_ext);
        div_last  = (cnt == CNTW'(WIDTH - 1));
        rem_sh    = {rem, cshift[WIDTH-1]};
        // remainder stays below d, and d never exceeds about 2**(WIDTH/2), so WIDTH bits suffice
        rem_nxt   = (rem_sh >= d) ? WIDTH'(rem_sh - d) : rem_sh[WIDTH-1:0];
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (go || load) state_nxt = S_SETUP;
            S_SETUP: state_nxt = (req_load && (seed_q <= ONE_W)) ? S_IDLE : S_CHECK;
            S_CHECK: state_nxt = (chk_fail || chk_found) ? S_IDLE : S_DIV;
            S_DIV:   if (div_last) state_nxt = S_CHECK;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode: idle means res/error are valid
    always_comb begin
        ready = (state == S_IDLE);
    end

    // Datapath registers: request capture, candidate formation, division and result update
    always_ff @(posedge clk) begin
        if (rst) begin
            res      <= ONE_W;
            error    <= 1'b0;
            req_load <= 1'b0;
            seed_q   <= '0;
            c        <= '0;
            d        <= '0;
            sq       <= '0;
            rem      <= '0;
            cshift   <= '0;
            cnt      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (go || load) begin
                        req_load <= load;
                        seed_q   <= seed;
                        error    <= 1'b0;
                    end
                end
                S_SETUP: begin
                    d  <= CW'(3);
                    sq <= SW'(9);
                    if (req_load) begin
                        if (seed_q <= ONE_W)      res <= ONE_W;
                        if (seed_q == TWO_W)      c <= CW'(2);
                        else if (seed_q[0])       c <= {1'b0, seed_q};
                        else                      c <= {1'b0, seed_q} + CW'(1);
                    end else begin
                        if (res == ONE_W)         c <= CW'(2);
                        else if (res == TWO_W)    c <= CW'(3);
                        else                      c <= {1'b0, res} + CW'(2);
                    end
                end
                S_CHECK: begin
                    if (chk_fail) begin
                        error <= 1'b1;
                    end else if (chk_found) begin
                        res   <= c[WIDTH-1:0];
                        error <= 1'b0;
                    end else begin
                        rem    <= '0;
                        cnt    <= '0;
                        cshift <= c[WIDTH-1:0];
                    end
                end
                S_DIV: begin
                    rem    <= rem_nxt;
                    cshift <= cshift << 1;
                    cnt    <= cnt + CNTW'(1);
                    if (div_last) begin
                        if (rem_nxt == '0) begin
                            c  <= c + CW'(2);
                            d  <= CW'(3);
                            sq <= SW'(9);
                        end else begin
                            // (d+2)^2 = d^2 + 4d + 4
                            d  <= d + CW'(2);
                            sq <= sq + (d_ext << 2) + SW'(4);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_primogen_wide.sv
// tb/tb_primogen_wide.sv - self-checking bench for primogen_wide (WIDTH=16 and WIDTH=8)
module tb_primogen_wide;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        go16 = 1'b0, load16 = 1'b0;
    logic [15:0] seed16 = '0;
    logic        ready16, error16;
    logic [15:0] res16;
    logic        go8 = 1'b0, load8 = 1'b0;
    logic [7:0]  seed8 = '0;
    logic        ready8, error8;
    logic [7:0]  res8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    primogen_wide #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .go(go16), .load(load16), .seed(seed16),
        .ready(ready16), .error(error16), .res(res16)
    );

    primogen_wide #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .go(go8), .load(load8), .seed(seed8),
        .ready(ready8), .error(error8), .res(res8)
    );

    typedef struct {
        bit          ld;
        logic [15:0] seed;
        logic [15:0] exp_res;
        bit          exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit is_prime(input int unsigned n);
        if (n < 2) return 1'b0;
        for (int unsigned k = 2; k * k <= n; k++)
            if (n % k == 0) return 1'b0;
        return 1'b1;
    endfunction

    // Reference: load -> smallest prime >= seed (1 for seed<=1); go -> smallest prime > res
    function automatic void model(input bit ld, input int unsigned s, input int unsigned maxv,
                                  inout int unsigned r, inout bit e);
        int unsigned start;
        if (ld && s <= 1) begin
            r = 1; e = 1'b0; return;
        end
        start = ld ? s : r + 1;
        e = 1'b1;
        for (int unsigned n = start; n <= maxv; n++) begin
            if (is_prime(n)) begin
                r = n; e = 1'b0; break;
            end
        end
    endfunction

    task automatic wait_ready(input bit w8, input string name);
        int n = 0;
        while (!(w8 ? ready8 : ready16) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_ready"}, {31'd0, (w8 ? ready8 : ready16)}, 32'd1);
    endtask

    task automatic op(input bit w8, input bit ld, input bit g, input logic [15:0] s, input string name);
        @(negedge clk);
        if (w8) begin load8 = ld; go8 = g; seed8 = s[7:0]; end
        else    begin load16 = ld; go16 = g; seed16 = s; end
        @(negedge clk);
        load8 = 1'b0; go8 = 1'b0; load16 = 1'b0; go16 = 1'b0;
        wait_ready(w8, name);
    endtask

    vec_t vt[19];
    int unsigned m_res;
    bit          m_err;

    initial begin
        for (int i = 0; i < 12; i++) vt[i].ld = 1'b0;
        vt[0].exp_res = 2;   vt[1].exp_res = 3;   vt[2].exp_res = 5;   vt[3].exp_res = 7;
        vt[4].exp_res = 11;  vt[5].exp_res = 13;  vt[6].exp_res = 17;  vt[7].exp_res = 19;
        vt[8].exp_res = 23;  vt[9].exp_res = 29;  vt[10].exp_res = 31; vt[11].exp_res = 37;
        for (int i = 0; i < 12; i++) begin vt[i].seed = 0; vt[i].exp_err = 1'b0; end
        vt[12] = '{1'b1, 16'd100,   16'd101,   1'b0};
        vt[13] = '{1'b0, 16'd0,     16'd103,   1'b0};
        vt[14] = '{1'b1, 16'd4,     16'd5,     1'b0};
        vt[15] = '{1'b1, 16'd0,     16'd1,     1'b0};
        vt[16] = '{1'b1, 16'd65521, 16'd65521, 1'b0};
        vt[17] = '{1'b0, 16'd0,     16'd65521, 1'b1};
        vt[18] = '{1'b1, 16'd7,     16'd7,     1'b0};

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'd0, ready16}, 32'd1);
        chk("rst_error", {31'd0, error16}, 32'd0);
        chk("rst_res", {16'd0, res16}, 32'd1);
        chk("rst_res_x", {31'd0, $isunknown(res16)}, 32'd0);
        rst = 1'b0;

        // directed table
        for (int i = 0; i < 19; i++) begin
            op(1'b0, vt[i].ld, ~vt[i].ld, vt[i].seed, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d_res", i), {16'd0, res16}, {16'd0, vt[i].exp_res});
            chk($sformatf("vec%0d_err", i), {31'd0, error16}, {31'd0, vt[i].exp_err});
        end

        // narrow instance at the top of its range
        op(1'b1, 1'b1, 1'b0, 16'd250, "w8_load");
        chk("w8_load_res", {24'd0, res8}, 32'd251);
        op(1'b1, 1'b0, 1'b1, 16'd0, "w8_go");
        chk("w8_go_err", {31'd0, error8}, 32'd1);
        chk("w8_go_res", {24'd0, res8}, 32'd251);

        // go pulses while busy are ignored
        op(1'b0, 1'b1, 1'b0, 16'd101, "busy_load");
        @(negedge clk); go16 = 1'b1;
        @(negedge clk); go16 = 1'b0;
        chk("busy_ready_low", {31'd0, ready16}, 32'd0);
        repeat (3) begin
            @(negedge clk); go16 = 1'b1;
            @(negedge clk); go16 = 1'b0;
        end
        wait_ready(1'b0, "busy_go");
        chk("busy_go_res", {16'd0, res16}, 32'd103);

        // load wins over go
        op(1'b0, 1'b1, 1'b1, 16'd20, "both");
        chk("both_res", {16'd0, res16}, 32'd23);

        // reset mid-computation
        @(negedge clk); load16 = 1'b1; seed16 = 16'd65000;
        @(negedge clk); load16 = 1'b0;
        repeat (40) @(negedge clk);
        chk("mid_busy", {31'd0, ready16}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_res", {16'd0, res16}, 32'd1);
        chk("mid_rst_ready", {31'd0, ready16}, 32'd1);
        chk("mid_rst_err", {31'd0, error16}, 32'd0);
        repeat (3000) @(negedge clk);
        chk("mid_late_res", {16'd0, res16}, 32'd1);

        // random go/load against the reference model
        m_res = 1; m_err = 1'b0;
        for (int i = 0; i < 24; i++) begin
            bit          ld;
            int unsigned s;
            ld = 1'($urandom_range(0, 1));
            s  = $urandom_range(0, 4000);
            model(ld, s, 65535, m_res, m_err);
            op(1'b0, ld, ~ld, 16'(s), $sformatf("rnd%0d", i));
            chk($sformatf("rnd%0d_res", i), {16'd0, res16}, m_res);
            chk($sformatf("rnd%0d_err", i), {31'd0, error16}, {31'd0, m_err});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
